bcd_multidigit_counter: RTL
===========================

Name: bcd_multidigit_counter

Overview:
- Parametrised N-digit synchronous BCD up/down counter with parallel load, a frozen-display register and per-digit 7-segment decode.
- Replaces chained single-digit ripple counters with one clock-synchronous block.
- Drives the board 7-segment displays directly.
- Provides a registered terminal-count pulse for cascading or event counting.

Parameters:
- N_DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
- BLANK_LZ, 1, 1 = blank leading-zero digits on the display; digit 0 is never blanked.

Ports:
- clk  in  1  system clock, all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load.
- load_val  in  4*N_DIGITS  BCD value to load; digit i is load_val[4i+3:4i].
- hold  in  1  1 = freeze the display register.
- count  out  4*N_DIGITS  current BCD count (registered).
- tc  out  1  terminal-count pulse, one clk wide.
- load_err  out  1  one-clk pulse: the load contained a digit above 9.
- disp  out  4*N_DIGITS  display register contents.
- seg  out  7*N_DIGITS  segments {a,b,c,d,e,f,g} for digit i at seg[7i+6:7i], active-high.

Behaviour:
- Reset (reset=0, asynchronous): count=0, disp=0, tc=0, load_err=0. Outputs stay at these values while reset is low.
- Release: the first update occurs on the first clk rising edge with reset=1.
- Priority per edge: load > en. With en=0 and load=0, count holds.
- Load:
  - count <= load_val, except any digit >9 is stored as 0.
  - load_err=1 on the next cycle if any digit was >9, else 0.
  - tc=0 on a load cycle, even if en=1.
- Up count (en=1, up=1):
  - Digit 0 increments.
  - Digit i increments only when all lower digits are 9; any digit at 9 that receives a carry goes to 0.
  - All-9 wraps to all-0, and tc=1 for the following cycle.
- Down count (en=1, up=0):
  - Digit 0 decrements.
  - Digit i decrements only when all lower digits are 0; any digit at 0 that receives a borrow goes to 9.
  - All-0 wraps to all-9, and tc=1 for the following cycle.
- Carry/borrow across all digits resolves within one clk; there is no ripple latency.
- tc and load_err are registered. Each is high exactly one cycle per event and is 0 otherwise.
- Display:
  - With hold=0, disp <= count on each edge, so disp lags count by one cycle.
  - With hold=1, disp keeps its value. Counting continues underneath.
  - When hold falls, disp shows the current count on the next edge.
- seg is combinational from disp. Codes, for a..g:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Any other value = 0000001 (dash). Such a value is unreachable in normal operation.
- Leading-zero blanking (BLANK_LZ=1): for i>0, digit i outputs 0000000 when it and all higher digits are 0.
- Direction change takes effect on the same edge that up is sampled; there is no extra step.
- Reset asserted mid-count or mid-hold clears everything immediately. No tc is generated by reset.
- Inputs are assumed synchronous to clk. The block contains no synchronisers.

Test Plan (N_DIGITS=3, BLANK_LZ=1):
- Reset low for 3 clk, then release with en=0 -> count=000, disp=000, seg digit0=1111110, digits 1–2=0000000, tc=0.
- load_val=0x998, load=1 for 1 clk; then en=1, up=1 for 3 clk:
  - count sequence 998 -> 999 -> 000 -> 001.
  - tc high only in the cycle after 999->000.
  - disp follows count one cycle later.
- load_val=0x001, then en=1, up=0 for 3 clk:
  - count 001 -> 000 -> 999 -> 998.
  - tc pulses once after the 000->999 wrap.
  - seg for 999 = 1111011 on all three digits.
- load_val=0x0A5 (digit 1 = A) -> count=005, load_err=1 for exactly 1 cycle; seg digit1 blanked (0000000).
- count=042 with hold=1 for 10 clk of up counting:
  - disp stays 042 while count reaches 052.
  - hold=0 -> disp=052 on the next edge.
- Counting at 517, assert reset for half a cycle -> count, disp, tc, load_err all 0 immediately, without waiting for clk; load and en in the same cycle -> load wins, tc=0.

Source files
------------

// File: rtl/bcd_multidigit_counter.sv
// N-digit synchronous BCD up/down counter with parallel load, freezable
// display register and per-digit 7-segment decode with leading-zero blanking.
module bcd_multidigit_counter #(
    parameter int unsigned N_DIGITS = 4,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] load_val,
    input  logic                  hold,
    output logic [4*N_DIGITS-1:0] count,
    output logic                  tc,
    output logic                  load_err,
    output logic [4*N_DIGITS-1:0] disp,
    output logic [7*N_DIGITS-1:0] seg
);

    localparam int unsigned CW = 4 * N_DIGITS;
    localparam int unsigned SW = 7 * N_DIGITS;

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] disp_q, disp_d;
    logic          tc_q, tc_d;
    logic          lerr_q, lerr_d;
    logic          carry;
    logic [3:0]    dig;
    logic          lz;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    // Next-state: load beats count; carry/borrow ripples through all digits combinationally.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        lerr_d  = 1'b0;
        carry   = 1'b1;
        dig     = 4'd0;
        if (load) begin
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                dig = load_val[4*i +: 4];
                if (dig > 4'd9) begin
                    lerr_d              = 1'b1;
                    count_d[4*i +: 4]   = 4'd0;
                end else begin
                    count_d[4*i +: 4]   = dig;
                end
            end
        end else if (en) begin
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                dig = count_q[4*i +: 4];
                if (carry) begin
                    if (up) begin
                        if (dig >= 4'd9) begin
                            count_d[4*i +: 4] = 4'd0;
                        end else begin
                            count_d[4*i +: 4] = dig + 4'd1;
                            carry             = 1'b0;
                        end
                    end else begin
                        if (dig == 4'd0) begin
                            count_d[4*i +: 4] = 4'd9;
                        end else begin
                            count_d[4*i +: 4] = dig - 4'd1;
                            carry             = 1'b0;
                        end
                    end
                end
            end
            // A carry surviving past the top digit means the counter wrapped.
            tc_d = carry;
        end
        disp_d = hold ? disp_q : count_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            disp_q  <= '0;
            tc_q    <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            disp_q  <= disp_d;
            tc_q    <= tc_d;
            lerr_q  <= lerr_d;
        end
    end

    // Segment decode from the display register, blanking zero digits above the highest non-zero one.
    always_comb begin
        seg = SW'(0);
        lz  = 1'b1;
        for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
            lz = lz & (disp_q[4*i +: 4] == 4'd0);
            if (BLANK_LZ && (i > 0) && lz) begin
                seg[7*i +: 7] = 7'b0000000;
            end else begin
                seg[7*i +: 7] = seg_decode(disp_q[4*i +: 4]);
            end
        end
    end

    assign count    = count_q;
    assign disp     = disp_q;
    assign tc       = tc_q;
    assign load_err = lerr_q;

endmodule
